// File: rtl/imm_field_encoder_pkg.sv
// Shared immediate-type codes and stage-1 record for the immediate field encoder.
// The codes mirror ITYPE/STYPE/BTYPE/UTYPE/JTYPE from the shared Parameters.v header.
package imm_field_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    typedef struct packed {
        logic [2:0]  itype;
        logic [31:0] base;
        logic [31:0] inst;
        logic        err;
    } stage1_t;

    function automatic logic is_known_type(input logic [2:0] t);
        return (t <= 3'd4);
    endfunction

endpackage

// File: rtl/imm_field_encoder_scatter.sv
// Combinational scatter of an immediate into the RV32I fields of a base instruction.
// The representability check exists only when IMM_RANGE_CHECK_EN is defined.
module imm_field_scatter
    import imm_field_encoder_pkg::*;
(
    input  logic [2:0]  in_type,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_inst,
    output logic [31:0] inst,
    output logic        err
);

    always_comb begin
        inst = in_inst;
        case (in_type)
            IMM_I: inst[31:20] = in_imm[11:0];
            IMM_S: begin
                inst[31:25] = in_imm[11:5];
                inst[11:7]  = in_imm[4:0];
            end
            IMM_B: begin
                inst[31]    = in_imm[12];
                inst[30:25] = in_imm[10:5];
                inst[11:8]  = in_imm[4:1];
                inst[7]     = in_imm[11];
            end
            IMM_U: inst[31:12] = in_imm[31:12];
            IMM_J: begin
                inst[31]    = in_imm[20];
                inst[30:21] = in_imm[10:1];
                inst[20]    = in_imm[11];
                inst[19:12] = in_imm[19:12];
            end
            default: inst = in_inst;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // An immediate fits when every discarded high bit equals the field's sign bit.
    always_comb begin
        err = 1'b0;
        case (in_type)
            IMM_I, IMM_S: err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            IMM_B: err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            IMM_U: err = |in_imm[11:0];
            IMM_J: err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            default: err = 1'b1;
        endcase
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/imm_field_encoder.sv
// Two-stage valid/ready pipeline that patches an immediate into an instruction word.
// Define IMM_RANGE_CHECK_EN to enable the range check, out_err and err_count.
module imm_field_encoder
    import imm_field_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [7:0]  err_count
);

    logic [31:0] scat_inst;
    logic        scat_err;

    logic        s1_valid_q, s1_valid_d;
    stage1_t     s1_q, s1_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_inst_q, s2_inst_d;
    logic        s2_err_q, s2_err_d;
    logic        s1_load, s2_load;

    imm_field_scatter u_scatter (
        .in_type (in_type),
        .in_imm  (in_imm),
        .in_inst (in_inst),
        .inst    (scat_inst),
        .err     (scat_err)
    );

    always_comb begin
        s2_load    = !s2_valid_q || out_ready;
        s1_load    = !s1_valid_q || s2_load;
        in_ready   = s1_load;

        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d = '{itype: in_type, base: in_inst, inst: scat_inst, err: scat_err};
            end
        end

        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;
        // Unknown types forward the registered base word untouched.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_inst_d = is_known_type(s1_q.itype) ? s1_q.inst : s1_q.base;
                s2_err_d  = s1_q.err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;

`ifdef IMM_RANGE_CHECK_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (s2_valid_q && out_ready && s2_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_imm_field_encoder.sv
// Self-checking bench for imm_field_encoder: vector table, backpressure, reset and random traffic.
// Expectations follow IMM_RANGE_CHECK_EN the same way the design does.
module tb_imm_field_encoder;
    import imm_field_encoder_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [31:0] in_imm;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_count;

    imm_field_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_imm    (in_imm),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic        rt;
        logic [2:0]  t;
        logic [31:0] imm;
    } exp_t;

    typedef struct {
        logic [2:0]  t;
        logic [31:0] imm;
        logic [31:0] inst;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    exp_t        cur_exp;
    int          exp_cnt = 0;
    logic        accepted = 1'b0;
    logic        last_out_valid = 1'b0;
    logic        stall_hold = 1'b0;
    logic [31:0] held_inst;
    logic        held_err;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference field placement written as masks and shifts on whole words.
    function automatic logic [31:0] model_inst(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] inst);
        case (t)
            3'd0: return (inst & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
            3'd1: return (inst & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            3'd2: return (inst & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                         | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
            3'd3: return (inst & 32'h00000FFF) | (imm & 32'hFFFFF000);
            3'd4: return (inst & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                         | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
            default: return inst;
        endcase
    endfunction

    function automatic logic model_repr(input logic [2:0] t, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (t)
            3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
            3'd2: return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
            3'd3: return (imm & 32'hFFF) == 32'd0;
            3'd4: return (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
            default: return 1'b0;
        endcase
    endfunction

    // Decoder-side immediate extraction, used for the round-trip property.
    function automatic logic [31:0] decode_imm(input logic [2:0] t, input logic [31:0] w);
        logic [31:0] v;
        v = 32'd0;
        case (t)
            3'd0: begin v = w >> 20; if (w[31]) v = v | 32'hFFFFF000; end
            3'd1: begin v = ((w >> 25) << 5) | ((w >> 7) & 32'h1F); if (w[31]) v = v | 32'hFFFFF000; end
            3'd2: begin
                v = (((w >> 31) & 32'h1) << 12) | (((w >> 7) & 32'h1) << 11)
                  | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
                if (w[31]) v = v | 32'hFFFFE000;
            end
            3'd3: v = w & 32'hFFFFF000;
            3'd4: begin
                v = (((w >> 31) & 32'h1) << 20) | (((w >> 12) & 32'hFF) << 12)
                  | (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
                if (w[31]) v = v | 32'hFFE00000;
            end
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic exp_t make_exp(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] inst);
        exp_t e;
        logic r;
        r     = model_repr(t, imm);
        e.inst = model_inst(t, imm, inst);
        e.err  = CHECK_ON && !r;
        e.rt   = r;
        e.t    = t;
        e.imm  = imm;
        return e;
    endfunction

    task automatic apply_stimulus(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] inst, input exp_t e);
        in_type  = t;
        in_imm   = imm;
        in_inst  = inst;
        cur_exp  = e;
        in_valid = 1'b1;
    endtask

    // Sampled mid-cycle: observes the handshakes that the next rising edge will commit.
    task automatic sample();
        exp_t e;
        if (!rst_n) begin
            accepted = 1'b0;
            return;
        end
        if (stall_hold && out_valid) begin
            check_output("stall_inst_stable", out_inst, held_inst);
            check_output("stall_err_stable", {31'd0, out_err}, {31'd0, held_err});
        end
        check_output("err_count", {24'd0, err_count}, exp_cnt);
        last_out_valid = out_valid;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_output("no_stale_result", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_output("out_inst", out_inst, e.inst);
                check_output("out_err", {31'd0, out_err}, {31'd0, e.err});
                if (e.rt) check_output("round_trip", decode_imm(e.t, out_inst), e.imm);
                if (e.err) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            end
        end
        stall_hold = out_valid && !out_ready;
        held_inst  = out_inst;
        held_err   = out_err;
        accepted   = in_valid && in_ready;
        if (accepted) sb.push_back(cur_exp);
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[10];
    exp_t        bp_exp[3];
    logic [31:0] bp_imm[3];
    int          idx;
    logic [2:0]  rt_t;
    logic [31:0] rt_imm;
    logic [31:0] rt_inst;
    exp_t        e0;

    initial begin
        tbl[0] = '{3'd0, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0};
        tbl[1] = '{3'd1, 32'h00000123, 32'h00002023, 32'h120021A3, 1'b0};
        tbl[2] = '{3'd2, 32'h00000800, 32'h00000063, 32'h000000E3, 1'b0};
        tbl[3] = '{3'd4, 32'hFFFFFFFE, 32'h0000006F, 32'hFFFFF06F, 1'b0};
        tbl[4] = '{3'd4, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1};
        tbl[5] = '{3'd2, 32'h00001001, 32'h00000063, 32'h80000063, 1'b1};
        tbl[6] = '{3'd3, 32'h12345678, 32'h00000037, 32'h12345037, 1'b1};
        tbl[7] = '{3'd7, 32'h00000ABC, 32'h12345678, 32'h12345678, 1'b1};
        tbl[8] = '{3'd0, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1};
        tbl[9] = '{3'd0, 32'h000007FF, 32'h00000093, 32'h7FF00093, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_type = 3'd0; in_imm = 32'd0; in_inst = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("reset_out_inst", out_inst, 32'd0);
        check_output("reset_out_err", {31'd0, out_err}, 32'd0);
        check_output("reset_err_count", {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        check_output("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Table vectors, one at a time, checking the two-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            e0 = make_exp(tbl[i].t, tbl[i].imm, tbl[i].inst);
            e0.inst = tbl[i].exp_inst;
            e0.err  = CHECK_ON && tbl[i].exp_err;
            apply_stimulus(tbl[i].t, tbl[i].imm, tbl[i].inst, e0);
            tick();
            check_output("vec_accepted", {31'd0, accepted}, 32'd1);
            in_valid = 1'b0;
            tick();
            check_output("vec_valid_after_1", {31'd0, last_out_valid}, 32'd0);
            tick();
            check_output("vec_valid_after_2", {31'd0, last_out_valid}, 32'd1);
        end
        tick();
        check_output("err_count_after_table", {24'd0, err_count}, CHECK_ON ? 32'd5 : 32'd0);

        // Backpressure: three requests against a stalled consumer.
        bp_imm[0] = 32'h00000010; bp_imm[1] = 32'h00000020; bp_imm[2] = 32'h00000030;
        for (int i = 0; i < 3; i++) bp_exp[i] = make_exp(3'd0, bp_imm[i], 32'h00000013);
        out_ready = 1'b0;
        idx = 0;
        apply_stimulus(3'd0, bp_imm[0], 32'h00000013, bp_exp[0]);
        for (int c = 0; c < 4; c++) begin
            tick();
            if (accepted) begin
                idx++;
                if (idx < 3) apply_stimulus(3'd0, bp_imm[idx], 32'h00000013, bp_exp[idx]);
                else in_valid = 1'b0;
            end
        end
        check_output("bp_accepts_while_stalled", idx, 32'd2);
        check_output("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 12 && !(idx == 3 && sb.size() == 0); c++) begin
            tick();
            if (accepted) begin
                idx++;
                if (idx < 3) apply_stimulus(3'd0, bp_imm[idx], 32'h00000013, bp_exp[idx]);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check_output("bp_all_delivered", sb.size(), 32'd0);

        // Random traffic against the reference model.
        accepted = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || accepted) begin
                if ($urandom_range(0, 99) < 70) begin
                    rt_t = 3'($urandom_range(0, 7));
                    case ($urandom_range(0, 3))
                        0: rt_imm = $urandom;
                        1: rt_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
                        2: rt_imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFFFFFE;
                        default: rt_imm = $urandom & 32'hFFFFF000;
                    endcase
                    rt_inst = $urandom;
                    apply_stimulus(rt_t, rt_imm, rt_inst, make_exp(rt_t, rt_imm, rt_inst));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        check_output("random_drained", sb.size(), 32'd0);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        apply_stimulus(3'd7, 32'd1, 32'hDEADBEEF, make_exp(3'd7, 32'd1, 32'hDEADBEEF));
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        sb.delete();
        exp_cnt = 0;
        stall_hold = 1'b0;
        check_output("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("midreset_err_count", {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;
        check_output("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_output("midreset_no_output", {31'd0, last_out_valid}, 32'd0);
        end

        // Saturation: 300 erroneous deliveries.
        apply_stimulus(3'd7, 32'd0, 32'h00000013, make_exp(3'd7, 32'd0, 32'h00000013));
        for (int c = 0; c < 300; c++) tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
        tick();
        check_output("sat_drained", sb.size(), 32'd0);
        check_output("err_count_saturated", {24'd0, err_count}, CHECK_ON ? 32'd255 : 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
